// File: rtl/ahb_apb_bridge_ctrl_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge: FSM states,
// AHB encodings and the fixed peripheral slot map.
package ahb_apb_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SETUP,
      ST_ACCESS,
      ST_ENDOK,
      ST_ERR1,
      ST_ERR2
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam int NUM_APB_SLAVES = 6;

   localparam logic [2:0] SLOT_UART0  = 3'd0;
   localparam logic [2:0] SLOT_TIMER  = 3'd1;
   localparam logic [2:0] SLOT_WDOG   = 3'd2;
   localparam logic [2:0] SLOT_DUALTM = 3'd3;
   localparam logic [2:0] SLOT_UART1  = 3'd4;
   localparam logic [2:0] SLOT_SPI    = 3'd5;

   function automatic logic [NUM_APB_SLAVES-1:0] slot_onehot(input logic [2:0] slot);
      return {{(NUM_APB_SLAVES-1){1'b0}}, 1'b1} << slot;
   endfunction

endpackage

// File: rtl/ahb_apb_bridge_ctrl_if.sv
// Bundles the AHB-Lite slave side and APB master side of the bridge.
// Valid/ready: an AHB transfer is taken when HSEL & HTRANS[1] & HREADY; an APB transfer ends in ACCESS when PREADY=1.
interface ahb_apb_bridge_ctrl_if #(parameter int ADDRWIDTH = 16);
   import ahb_apb_bridge_pkg::*;

   logic                 HSEL;
   logic [ADDRWIDTH-1:0] HADDR;
   logic [1:0]           HTRANS;
   logic [2:0]           HSIZE;
   logic                 HWRITE;
   logic                 HREADY;
   logic [31:0]          HWDATA;
   logic                 HREADYOUT;
   logic [31:0]          HRDATA;
   logic                 HRESP;
   logic [ADDRWIDTH-1:0] PADDR;
   logic [5:0]           PSEL;
   logic                 PENABLE;
   logic                 PWRITE;
   logic [31:0]          PWDATA;
   logic [3:0]           PSTRB;
   logic                 PREADY;
   logic [31:0]          PRDATA;
   logic                 PSLVERR;
   state_t               dbg_state;

   modport slave (
      input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
      input  PREADY, PRDATA, PSLVERR,
      output HREADYOUT, HRDATA, HRESP,
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, dbg_state
   );

   modport master (
      output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
      output PREADY, PRDATA, PSLVERR,
      input  HREADYOUT, HRDATA, HRESP,
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, dbg_state
   );

endinterface

// File: rtl/ahb_apb_bridge_ctrl_decoder.sv
// Address-phase decode: peripheral slot, illegal-access flag and APB byte strobes.
module apb_slot_decoder
   import ahb_apb_bridge_pkg::*;
(
   input  logic [3:0] i_region,
   input  logic [1:0] i_byte_off,
   input  logic [2:0] i_hsize,
   input  logic       i_hwrite,
   output logic [2:0] o_slot,
   output logic       o_illegal,
   output logic [3:0] o_pstrb
);

   assign o_slot    = i_region[2:0];
   assign o_illegal = (i_region >= 4'(NUM_APB_SLAVES)) || (i_hsize > HSIZE_WORD);

   always_comb begin
      o_pstrb = 4'b0000;
      if (i_hwrite) begin
         case (i_hsize)
            HSIZE_BYTE: o_pstrb = 4'b0001 << i_byte_off;
            HSIZE_HALF: o_pstrb = 4'b0011 << {i_byte_off[1], 1'b0};
            default:    o_pstrb = 4'b1111;
         endcase
      end
   end

endmodule

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-Lite slave to APB master bridge: sequences SETUP/ACCESS, maps PREADY/PSLVERR
// into AHB wait states and OKAY/ERROR responses, with an optional ACCESS timeout.
module ahb_apb_bridge_ctrl
   import ahb_apb_bridge_pkg::*;
#(
   parameter int ADDRWIDTH = 16,
   parameter int TIMEOUT   = 0
)(
   input  logic                 HCLK,
   input  logic                 HRESETn,
   ahb_apb_bridge_ctrl_if.slave bus
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_accept;
   logic                 w_can_accept;
   logic                 w_illegal;
   logic                 w_timeout;
   logic [2:0]           w_slot;
   logic [3:0]           w_pstrb;
   logic [2:0]           r_slot;
   logic [TW-1:0]        r_tcnt;
   logic                 r_hreadyout;
   logic                 r_hresp;
   logic [31:0]          r_hrdata;
   logic [ADDRWIDTH-1:0] r_paddr;
   logic [5:0]           r_psel;
   logic                 r_penable;
   logic                 r_pwrite;
   logic [31:0]          r_pwdata;
   logic [3:0]           r_pstrb;

   apb_slot_decoder u_dec (
      .i_region   (bus.HADDR[ADDRWIDTH-1:ADDRWIDTH-4]),
      .i_byte_off (bus.HADDR[1:0]),
      .i_hsize    (bus.HSIZE),
      .i_hwrite   (bus.HWRITE),
      .o_slot     (w_slot),
      .o_illegal  (w_illegal),
      .o_pstrb    (w_pstrb)
   );

   assign w_accept     = bus.HSEL && bus.HREADY &&
                         (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
   assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_ENDOK) || (r_state == ST_ERR2);
   // r_tcnt holds the number of ACCESS cycles already completed before this one
   assign w_timeout    = (TIMEOUT > 0) && !bus.PREADY && (r_tcnt == TW'(TIMEOUT - 1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_ENDOK, ST_ERR2: begin
            if (w_accept) w_state_nxt = w_illegal ? ST_ERR1 : ST_WAIT;
            else          w_state_nxt = ST_IDLE;
         end
         ST_WAIT:  w_state_nxt = ST_SETUP;
         ST_SETUP: w_state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (bus.PREADY)     w_state_nxt = bus.PSLVERR ? ST_ERR1 : ST_ENDOK;
            else if (w_timeout) w_state_nxt = ST_ERR1;
         end
         ST_ERR1: w_state_nxt = ST_ERR2;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they align with r_state.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= ST_IDLE;
         r_hreadyout <= 1'b1;
         r_hresp     <= 1'b0;
         r_hrdata    <= '0;
         r_paddr     <= '0;
         r_psel      <= '0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_pstrb     <= '0;
         r_slot      <= '0;
         r_tcnt      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_hreadyout <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ENDOK) ||
                        (w_state_nxt == ST_ERR2);
         r_hresp     <= (w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2);
         r_psel      <= ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS)) ?
                        slot_onehot(r_slot) : '0;
         r_penable   <= (w_state_nxt == ST_ACCESS);

         if (w_can_accept && w_accept) begin
            r_slot   <= w_slot;
            r_paddr  <= {bus.HADDR[ADDRWIDTH-1:2], 2'b00};
            r_pwrite <= bus.HWRITE;
            r_pstrb  <= w_pstrb;
         end

         if (r_state == ST_WAIT) r_pwdata <= bus.HWDATA;

         if (r_state == ST_ACCESS && bus.PREADY && !r_pwrite) r_hrdata <= bus.PRDATA;

         if (r_state != ST_ACCESS) r_tcnt <= '0;
         else                      r_tcnt <= r_tcnt + 1'b1;
      end
   end

   assign bus.HREADYOUT = r_hreadyout;
   assign bus.HRESP     = r_hresp;
   assign bus.HRDATA    = r_hrdata;
   assign bus.PADDR     = r_paddr;
   assign bus.PSEL      = r_psel;
   assign bus.PENABLE   = r_penable;
   assign bus.PWRITE    = r_pwrite;
   assign bus.PWDATA    = r_pwdata;
   assign bus.PSTRB     = r_pstrb;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Bench for ahb_apb_bridge_ctrl: directed transfers, a per-cycle expected-output
// queue built from the bridge timing rules, and a negedge compare process.
module tb_ahb_apb_bridge_ctrl;
  import ahb_apb_bridge_pkg::*;

  localparam int AW   = 16;
  localparam int TOUT = 4;

  typedef struct {
    int              cyc;
    logic            hro;
    logic            hresp;
    logic [5:0]      psel;
    logic            pen;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [3:0]      pstrb;
    logic [31:0]     pwdata;
    logic [31:0]     hrdata;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          wait_cnt = 0;
  bit          chk_en = 1'b0;
  logic [31:0] m_hrdata = '0;
  logic [31:0] last_hrdata = '0;

  always #5 HCLK = ~HCLK;

  ahb_apb_bridge_ctrl_if #(.ADDRWIDTH(AW)) bus ();

  ahb_apb_bridge_ctrl #(.ADDRWIDTH(AW), .TIMEOUT(TOUT)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Strobe from byte lanes covered by an aligned access of 2**sz bytes.
  function automatic logic [3:0] model_strb(input logic [AW-1:0] a, input logic [2:0] sz,
                                            input logic wr);
    logic [3:0] s;
    int nb, off;
    s = '0;
    if (!wr || sz > 3'd2) return s;
    nb  = 1 << sz;
    off = int'(a[1:0]) & ~(nb - 1);
    for (int b = 0; b < 4; b++) if (b >= off && b < off + nb) s[b] = 1'b1;
    return s;
  endfunction

  // Compare process
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (chk_en) begin
        if (bus.HREADYOUT == 1'b0) wait_cnt++;
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          last_hrdata = e.hrdata;
          chk("cyc_ctrl", {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE},
              {e.hro, e.hresp, e.psel, e.pen});
          chk("cyc_hrdata", bus.HRDATA, e.hrdata);
          if (e.psel != 6'b0)
            chk("cyc_apb", {bus.PADDR, bus.PWRITE, bus.PSTRB, bus.PWDATA},
                {e.paddr, e.pwrite, e.pstrb, e.pwdata});
        end else begin
          chk("idle_ctrl", {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE},
              {1'b1, 1'b0, 6'b0, 1'b0});
          chk("idle_hrdata", bus.HRDATA, last_hrdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_in();
    bus.HSEL    = 1'b0;
    bus.HTRANS  = HTRANS_IDLE;
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = $urandom;
  endtask

  task automatic push(input exp_t t, input int c, input logic hro, input logic hresp,
                      input logic [5:0] ps, input logic pen);
    t.cyc = c; t.hro = hro; t.hresp = hresp; t.psel = ps; t.pen = pen;
    exp_q.push_back(t);
  endtask

  // Drives one transfer whose address phase is the current cycle; returns at #1
  // into its final response cycle so a following call is back-to-back.
  task automatic xfer(input logic [AW-1:0] addr, input logic [2:0] sz, input logic wr,
                      input logic [31:0] wdata, input int nwait, input logic slverr,
                      input logic [31:0] rdata);
    exp_t t;
    int   c0, slot, acc, last, i;
    bit   legal, tout;
    logic [5:0] oh;
    c0    = cyc;
    slot  = int'(addr[AW-1:AW-4]);
    legal = (slot < NUM_APB_SLAVES) && (sz <= 3'd2);
    oh    = legal ? 6'(1 << slot) : 6'b0;
    tout  = (nwait >= TOUT);
    acc   = tout ? TOUT : nwait + 1;
    t.paddr  = {addr[AW-1:2], 2'b00};
    t.pwrite = wr;
    t.pstrb  = model_strb(addr, sz, wr);
    t.pwdata = wdata;
    t.hrdata = m_hrdata;
    if (!legal) begin
      push(t, c0 + 1, 1'b0, 1'b1, 6'b0, 1'b0);
      push(t, c0 + 2, 1'b1, 1'b1, 6'b0, 1'b0);
      last = c0 + 2;
    end else begin
      push(t, c0 + 1, 1'b0, 1'b0, 6'b0, 1'b0);
      push(t, c0 + 2, 1'b0, 1'b0, oh, 1'b0);
      for (int k = 0; k < acc; k++) push(t, c0 + 3 + k, 1'b0, 1'b0, oh, 1'b1);
      if (!wr && !tout) m_hrdata = rdata;
      t.hrdata = m_hrdata;
      if (tout || slverr) begin
        push(t, c0 + 3 + acc, 1'b0, 1'b1, 6'b0, 1'b0);
        push(t, c0 + 4 + acc, 1'b1, 1'b1, 6'b0, 1'b0);
        last = c0 + 4 + acc;
      end else begin
        push(t, c0 + 3 + acc, 1'b1, 1'b0, 6'b0, 1'b0);
        last = c0 + 3 + acc;
      end
    end
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HADDR = addr; bus.HSIZE = sz;
    bus.HWRITE = wr; bus.HREADY = 1'b1; bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
    bus.PRDATA = $urandom;
    step();
    idle_in();
    bus.HWDATA = wdata;
    for (int c = c0 + 2; c <= last; c++) begin
      step();
      idle_in();
      i = c - c0 - 3;
      if (legal && i >= 0 && i < acc) begin
        bus.PREADY  = (i == nwait);
        bus.PSLVERR = (i == nwait) ? slverr : 1'b0;
        bus.PRDATA  = (i == nwait) ? rdata : $urandom;
      end
    end
  endtask

  initial begin
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE; bus.HSIZE = HSIZE_WORD;
    bus.HWRITE = 1'b0; bus.HREADY = 1'b1; bus.HWDATA = '0;
    bus.PREADY = 1'b1; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
    HRESETn = 1'b0;
    repeat (2) step();
    chk("rst_outs", {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB},
        {1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 4'b0});
    chk("rst_data", {bus.HRDATA, bus.PWDATA}, 64'h0);
    chk("rst_paddr", bus.PADDR, 64'h0);
    chk("rst_state", bus.dbg_state, ST_IDLE);
    chk("model_strb_word", model_strb(16'h1004, HSIZE_WORD, 1'b1), 4'hF);
    chk("model_strb_read", model_strb(16'h5003, HSIZE_BYTE, 1'b0), 4'h0);
    chk("model_strb_byte", model_strb(16'h0001, HSIZE_BYTE, 1'b1), 4'h2);
    chk("model_strb_half", model_strb(16'h3002, HSIZE_HALF, 1'b1), 4'hC);
    HRESETn = 1'b1;
    step();
    chk_en = 1'b1;
    step();

    wait_cnt = 0;
    xfer(16'h1004, HSIZE_WORD, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h0);
    chk("t1_wait_states", wait_cnt, 3);
    chk("t1_okay", {bus.HREADYOUT, bus.HRESP}, 2'b10);
    step();

    wait_cnt = 0;
    xfer(16'h5003, HSIZE_BYTE, 1'b0, 32'hCAFE_F00D, 3, 1'b0, 32'h0000_00A5);
    chk("t2_wait_states", wait_cnt, 6);
    chk("t2_hrdata", bus.HRDATA, 32'h0000_00A5);
    step();

    wait_cnt = 0;
    xfer(16'h2000, HSIZE_WORD, 1'b1, 32'h0000_00FF, 0, 1'b1, 32'h0);
    chk("t3_wait_states", wait_cnt, 4);
    chk("t3_err2", {bus.HREADYOUT, bus.HRESP}, 2'b11);
    step();

    wait_cnt = 0;
    xfer(16'h7000, HSIZE_WORD, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    chk("t4_slot_wait", wait_cnt, 1);
    xfer(16'h0000, 3'd3, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    chk("t4_size_err2", {bus.HREADYOUT, bus.HRESP}, 2'b11);
    step();

    xfer(16'h3002, HSIZE_HALF, 1'b1, 32'hAAAA_5555, 1, 1'b0, 32'h0);
    xfer(16'h4000, HSIZE_WORD, 1'b0, 32'h1111_2222, 0, 1'b0, 32'hDEAD_BEEF);
    xfer(16'h0001, HSIZE_BYTE, 1'b1, 32'h0000_3300, 0, 1'b0, 32'h0);
    chk("t5_hrdata_hold", bus.HRDATA, 32'hDEAD_BEEF);
    step();

    wait_cnt = 0;
    xfer(16'h1008, HSIZE_WORD, 1'b0, 32'h0, 1000, 1'b0, 32'h0);
    chk("t6_timeout_waits", wait_cnt, 7);
    step();
    xfer(16'h0000, HSIZE_WORD, 1'b1, 32'h0BAD_F00D, 0, 1'b0, 32'h0);
    step();

    chk_en = 1'b0;
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HADDR = 16'h4010;
    bus.HSIZE = HSIZE_WORD; bus.HWRITE = 1'b1;
    step();
    idle_in();
    bus.HWDATA = 32'h7777_8888;
    step();
    step();
    bus.PREADY = 1'b0;
    chk("t7_access", {bus.PSEL, bus.PENABLE}, {6'b010000, 1'b1});
    #2 HRESETn = 1'b0;
    #1;
    chk("t7_rst_ctrl", {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE},
        {1'b1, 1'b0, 6'b0, 1'b0});
    chk("t7_rst_regs", {bus.HRDATA, bus.PWRITE, bus.PSTRB, bus.PADDR}, 64'h0);
    bus.PREADY = 1'b1;
    step();
    step();
    HRESETn = 1'b1;
    m_hrdata = '0;
    last_hrdata = '0;
    step();
    chk_en = 1'b1;
    xfer(16'h4010, HSIZE_WORD, 1'b1, 32'h55AA_55AA, 2, 1'b0, 32'h0);
    step();
    step();
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
